bitmap_index_encoder: RTL and testbench
=======================================

Name: bitmap_index_encoder

Overview:
- Sequential inverse of the binary-to-one-hot decoders.
- Accepts an N-bit request bitmap (e.g. TLB hit vector, issue-ready mask, register-valid mask) and emits the index of every set bit, one per handshake, lowest index first.
- Sits between bitmap-producing logic and index-consuming logic (regfile port, TLB entry select).
- Flushable for pipeline cancel.

Parameters:
- IDX_WIDTH, 5, width of emitted index.
- N, 1<<IDX_WIDTH, bitmap width; legal range 2..64.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- i_flush  input  1  abort current bitmap, return to IDLE
- i_load_valid  input  1  new bitmap offered
- o_load_ready  output  1  block can accept bitmap
- i_bitmap  input  N  bitmap to encode
- o_idx_valid  output  1  o_idx holds a valid index
- i_idx_ready  input  1  consumer accepts o_idx
- o_idx  output  IDX_WIDTH  index of lowest remaining set bit
- o_idx_last  output  1  o_idx is the final set bit of this bitmap
- o_remain  output  IDX_WIDTH+1  popcount of remaining bitmap, including the bit on o_idx
- o_done  output  1  one-cycle pulse: bitmap fully consumed

Behaviour:
- Reset and clock: clock clk; reset rst_n, synchronous, active-low. Reset has priority over all other inputs.
- Values after reset:
  - state=IDLE, internal bitmap reg=0.
  - o_idx_valid=0, o_idx=0, o_idx_last=0, o_remain=0, o_done=0.
  - o_load_ready=1, unless i_flush is asserted.
- States: IDLE, BUSY.
- IDLE:
  - o_load_ready = !i_flush.
  - Load handshake = i_load_valid & o_load_ready.
  - Handshake with i_bitmap!=0: reg<=i_bitmap, go to BUSY next cycle.
  - Handshake with i_bitmap==0: stay IDLE, assert o_done the next cycle, emit no index.
- BUSY:
  - o_load_ready=0, o_idx_valid=1.
  - o_idx = lowest set bit of reg, combinational from reg.
  - o_idx_last = (o_remain==1).
  - On i_idx_ready: clear bit o_idx in reg.
  - If that bit was the last one: go to IDLE and pulse o_done in the first IDLE cycle.
  - If i_idx_ready=0: o_idx, o_idx_last and o_remain hold stable (AXI-style; valid never drops without a handshake or flush).
- Latency:
  - First index is visible 1 cycle after the load handshake.
  - One index per cycle under continuous ready.
  - A bitmap with k set bits consumes k BUSY cycles.
  - Next load is accepted in the cycle after the last handshake. One bubble between bitmaps is intended.
- Outputs while IDLE: o_idx_valid=0, o_idx=0, o_remain=0.
- Flush:
  - i_flush in any state: reg<=0, state<=IDLE next cycle, no o_done pulse.
  - An index handshake in the same cycle as i_flush is discarded.
  - A concurrent load is refused because o_load_ready=0.
- Boundaries:
  - Bit N-1 set alone → o_idx=N-1, o_idx_last=1.
  - All ones → N handshakes, indices 0..N-1 in order, o_remain counts N..1.
  - o_remain is IDX_WIDTH+1 bits so that N fits.
- Bitmaps are not merged; i_bitmap is ignored outside the load handshake.

Decomposition:
- Shared constants header: state encodings (IDLE/BUSY) only. No new typedefs.
- Sub-module prio_encoder:
  - Parameters N, IDX_WIDTH.
  - Inputs: i_in[N-1:0].
  - Outputs: o_idx (lowest set bit), o_valid (|i_in).
  - Pure combinational, reusable elsewhere.
- Popcount: a local function or generate adder tree inside the top module.
- State and bitmap registers: plain always blocks or the shared enabled-dff cell.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with i_load_valid=1 → o_load_ready=1, o_idx_valid=0, o_remain=0, o_done=0; no load is captured.
2. Load 0x0000_0091, i_idx_ready=1 continuously → o_idx = 0, 4, 7 on consecutive cycles; o_remain = 3, 2, 1; o_idx_last only on idx 7; o_done pulses next cycle; o_load_ready=1 after.
3. Backpressure: load 0x8000_0001, i_idx_ready=0 for 4 cycles → o_idx=0 stable with o_remain=2; then ready=1 → 0, then 31 with last=1.
4. Zero bitmap: load 0x0 → no o_idx_valid; o_done=1 exactly one cycle later; a new load is accepted that same cycle.
5. Flush mid-stream: load 0xFFFF_FFFF, consume 3 indices, assert i_flush together with i_idx_ready → state IDLE next cycle, o_idx_valid=0, no o_done; load 0x2 → o_idx=1.
6. All-ones full sweep: load 0xFFFF_FFFF, random ready → 32 indices 0..31 in order, no duplicates; scoreboard matches a reference popcount and lowest-bit model.

Source files
------------

// File: rtl/bitmap_index_encoder_pkg.sv
// Shared constants for the bitmap index encoder: FSM state encodings.
package bitmap_index_encoder_pkg;

  // IDLE: waiting for a bitmap. BUSY: emitting indices of the held bitmap.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/bitmap_index_encoder_prio_encoder.sv
// Combinational priority encoder: index of the lowest set bit plus an
// any-bit-set flag. With no bit set, o_idx is 0 and o_valid is 0.
module prio_encoder #(
  parameter int IDX_WIDTH = 5,
  parameter int N         = 1 << IDX_WIDTH
) (
  input  logic [N-1:0]         i_in,
  output logic [IDX_WIDTH-1:0] o_idx,
  output logic                 o_valid
);

  // Scan from the top down so the lowest set bit is the final assignment.
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_in[i]) begin
        o_idx = IDX_WIDTH'(i);
      end
    end
  end

  // Any bit set.
  assign o_valid = |i_in;

endmodule

// File: rtl/bitmap_index_encoder.sv
// Bitmap index encoder: accepts an N-bit bitmap and emits the index of each
// set bit, lowest first, one per idx handshake. A zero bitmap produces only
// an o_done pulse. i_flush drops the held bitmap without an o_done pulse.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. The load side transfers on i_load_valid & o_load_ready; the
// index side on o_idx_valid & i_idx_ready. o_idx_valid never drops without
// a transfer or a flush, and o_idx/o_idx_last/o_remain hold while stalled.
// A transfer in a cycle with i_flush high is discarded.
module bitmap_index_encoder
  import bitmap_index_encoder_pkg::*;
#(
  parameter int IDX_WIDTH = 5,
  parameter int N         = 1 << IDX_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_flush,
  input  logic                 i_load_valid,
  output logic                 o_load_ready,
  input  logic [N-1:0]         i_bitmap,
  output logic                 o_idx_valid,
  input  logic                 i_idx_ready,
  output logic [IDX_WIDTH-1:0] o_idx,
  output logic                 o_idx_last,
  output logic [IDX_WIDTH:0]   o_remain,
  output logic                 o_done,
  output state_t               o_state
);

  // Number of set bits; IDX_WIDTH+1 bits so a full bitmap of N fits.
  function automatic logic [IDX_WIDTH:0] popcount(input logic [N-1:0] v);
    logic [IDX_WIDTH:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + {{IDX_WIDTH{1'b0}}, v[i]};
    end
    return c;
  endfunction

  state_t               state_q, state_d;
  logic [N-1:0]         bitmap_q, bitmap_d;
  logic                 done_q, done_d;

  logic [IDX_WIDTH-1:0] enc_idx;
  logic                 any_set;
  logic [IDX_WIDTH:0]   remain;
  logic                 is_last;
  logic                 load_ready;
  logic                 load_hs;
  logic                 idx_valid;
  logic                 idx_hs;

  prio_encoder #(
    .IDX_WIDTH (IDX_WIDTH),
    .N         (N)
  ) u_prio (
    .i_in    (bitmap_q),
    .o_idx   (enc_idx),
    .o_valid (any_set)
  );

  assign remain  = popcount(bitmap_q);
  assign is_last = (remain == (IDX_WIDTH + 1)'(1));

  // Next-state, next-bitmap and handshake decode; flush overrides everything.
  always_comb begin
    state_d    = state_q;
    bitmap_d   = bitmap_q;
    done_d     = 1'b0;
    load_ready = 1'b0;
    load_hs    = 1'b0;
    idx_valid  = 1'b0;
    idx_hs     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_ready = !i_flush;
        load_hs    = i_load_valid & load_ready;
        if (load_hs) begin
          if (|i_bitmap) begin
            bitmap_d = i_bitmap;
            state_d  = ST_BUSY;
          end else begin
            // Empty bitmap: nothing to emit, report completion right away.
            done_d = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        idx_valid = any_set;
        idx_hs    = idx_valid & i_idx_ready & !i_flush;
        if (idx_hs) begin
          // Clearing the lowest set bit: v & (v - 1).
          bitmap_d = bitmap_q & (bitmap_q - N'(1));
          if (is_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
    endcase
    if (i_flush) begin
      state_d  = ST_IDLE;
      bitmap_d = '0;
      done_d   = 1'b0;
    end
  end

  // State, bitmap and done-pulse registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bitmap_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitmap_q <= bitmap_d;
      done_q   <= done_d;
    end
  end

  // Index outputs are forced to zero whenever no index is being offered.
  assign o_load_ready = load_ready;
  assign o_idx_valid  = idx_valid;
  assign o_idx        = idx_valid ? enc_idx : '0;
  assign o_remain     = idx_valid ? remain : '0;
  assign o_idx_last   = idx_valid & is_last;
  assign o_done       = done_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_bitmap_index_encoder.sv
// Testbench for bitmap_index_encoder: directed scenarios plus randomized
// bitmaps, checked by a scoreboard against a set-bit-list reference model.
module tb_bitmap_index_encoder;
  import bitmap_index_encoder_pkg::*;

  localparam int IDX_WIDTH = 5;
  localparam int N         = 1 << IDX_WIDTH;
  localparam int W         = 2 * IDX_WIDTH + 2;  // {idx, last, remain}
  localparam int LAST_POS  = IDX_WIDTH + 1;

  logic                 clk;
  logic                 rst_n;
  logic                 i_flush;
  logic                 i_load_valid;
  logic                 o_load_ready;
  logic [N-1:0]         i_bitmap;
  logic                 o_idx_valid;
  logic                 i_idx_ready;
  logic [IDX_WIDTH-1:0] o_idx;
  logic                 o_idx_last;
  logic [IDX_WIDTH:0]   o_remain;
  logic                 o_done;
  state_t               o_state;

  int total = 0;
  int bad   = 0;
  int ready_mode = 1;  // 0: hold low, 1: hold high, 2: random

  logic [W-1:0] exp_q[$];
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;

  bitmap_index_encoder #(
    .IDX_WIDTH (IDX_WIDTH),
    .N         (N)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (i_flush),
    .i_load_valid (i_load_valid),
    .o_load_ready (o_load_ready),
    .i_bitmap     (i_bitmap),
    .o_idx_valid  (o_idx_valid),
    .i_idx_ready  (i_idx_ready),
    .o_idx        (o_idx),
    .o_idx_last   (o_idx_last),
    .o_remain     (o_remain),
    .o_done       (o_done),
    .o_state      (o_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       i_idx_ready = 1'b0;
      1:       i_idx_ready = 1'b1;
      default: i_idx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- scoreboard / reference model ----------------
  // The model holds the list of expected {idx, last, remain} tuples for the
  // current bitmap; it is built from the bitmap's set bits in ascending order.
  always @(negedge clk) begin
    logic [W-1:0] t;
    logic         done_n;
    int           cnt;
    int           k;
    int           rem;
    if (!rst_n) begin
      exp_q.delete();
      m_busy = 1'b0;
      m_done = 1'b0;
    end else begin
      check("load_ready", 64'(o_load_ready), 64'(!m_busy && !i_flush));
      check("idx_valid", 64'(o_idx_valid), 64'(m_busy));
      check("done", 64'(o_done), 64'(m_done));
      if (m_busy) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL idx_tuple: got=%0h want=<empty queue>", {o_idx, o_idx_last, o_remain});
        end else begin
          check("idx_tuple", 64'({o_idx, o_idx_last, o_remain}), 64'(exp_q[0]));
        end
      end else begin
        check("idle_outs", 64'({o_idx, o_idx_last, o_remain}), 64'(0));
      end
      done_n = 1'b0;
      if (i_flush) begin
        exp_q.delete();
        m_busy = 1'b0;
      end else if (m_busy && i_idx_ready) begin
        if (exp_q.size() > 0) begin
          t = exp_q.pop_front();
          if (t[LAST_POS]) begin
            m_busy = 1'b0;
            done_n = 1'b1;
          end
        end
      end else if (!m_busy && i_load_valid) begin
        if (i_bitmap == '0) begin
          done_n = 1'b1;
        end else begin
          cnt = $countones(i_bitmap);
          k   = 0;
          for (int i = 0; i < N; i++) begin
            if (i_bitmap[i]) begin
              rem = cnt - k;
              exp_q.push_back({IDX_WIDTH'(i), (rem == 1), (IDX_WIDTH + 1)'(rem)});
              k++;
            end
          end
          m_busy = 1'b1;
        end
      end
      m_done = done_n;
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic load(input logic [N-1:0] bm);
    logic acc;
    acc          = 1'b0;
    i_load_valid = 1'b1;
    i_bitmap     = bm;
    for (int c = 0; c < 100 && !acc; c++) begin
      @(negedge clk);
      acc = o_load_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL load_timeout: got=not_accepted want=accepted bm=%0h", bm);
    end
    i_load_valid = 1'b0;
    i_bitmap     = N'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    logic idle;
    idle = 1'b0;
    for (int c = 0; c < budget && !idle; c++) begin
      @(negedge clk);
      idle = o_load_ready && !o_idx_valid;
      @(posedge clk);
      #1;
    end
    if (!idle) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got=busy want=idle");
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic flush_pulse();
    i_flush = 1'b1;
    cycles(1);
    i_flush = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [N-1:0] bm;
    rst_n        = 1'b0;
    i_flush      = 1'b0;
    i_load_valid = 1'b1;
    i_bitmap     = N'(32'h0000_00FF);
    i_idx_ready  = 1'b1;

    // Reset with a load offered: nothing may be captured.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_load_ready", 64'(o_load_ready), 64'(1));
    check("rst_idx_valid", 64'(o_idx_valid), 64'(0));
    check("rst_remain", 64'(o_remain), 64'(0));
    check("rst_done", 64'(o_done), 64'(0));
    check("rst_idx", 64'(o_idx), 64'(0));
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    i_load_valid = 1'b0;
    cycles(2);

    // Basic sweep with continuous ready.
    ready_mode = 1;
    load(N'(32'h0000_0091));
    wait_idle(50);

    // Backpressure: indices hold while ready is low.
    ready_mode = 0;
    load(N'(32'h8000_0001));
    cycles(4);
    ready_mode = 1;
    wait_idle(50);

    // Zero bitmap, then a load in the done cycle.
    load('0);
    load(N'(32'h0000_0010));
    wait_idle(50);

    // Flush mid-stream with a concurrent index handshake.
    load('1);
    cycles(3);
    flush_pulse();
    cycles(1);
    load(N'(32'h0000_0002));
    wait_idle(50);

    // Flush while idle refuses a concurrent load.
    i_load_valid = 1'b1;
    i_bitmap     = N'(32'h0000_0004);
    flush_pulse();
    i_load_valid = 1'b0;
    cycles(2);

    // Single top bit, then all ones under random ready.
    load(N'(1) << (N - 1));
    wait_idle(50);
    ready_mode = 2;
    load('1);
    wait_idle(400);

    // Randomized bitmaps, ready patterns and occasional flushes.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0:       bm = '0;
        1:       bm = N'(1) << $urandom_range(0, N - 1);
        2:       bm = N'($urandom);
        3:       bm = N'($urandom & $urandom);
        default: bm = ~(N'($urandom_range(0, 7)));
      endcase
      ready_mode = $urandom_range(1, 2);
      load(bm);
      if ($urandom_range(0, 4) == 0) begin
        cycles($urandom_range(0, 6));
        flush_pulse();
      end
      wait_idle(400);
    end

    cycles(3);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
